// File: rtl/inst_rom_loader_pkg.sv
// Shared definitions for the instruction ROM loader.
//   ADDR_W_DEF : default word-address width (64-word instruction memory)
//   CSUM_W     : running checksum width
//   state_t    : loader FSM encoding
package inst_rom_loader_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int CSUM_W     = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

endpackage

// File: rtl/inst_rom_loader_byte_packer.sv
// Assembles four streamed bytes into one little-endian 32-bit word.
//   clk, rst   : clock, async active-low reset
//   clr        : restart at byte 0 (new load)
//   push       : a data byte is accepted this cycle
//   byte_in    : the data byte
//   word       : assembled word (first byte lands in [7:0])
//   word_done  : push of the fourth byte of a word (combinational pulse)
module inst_rom_loader_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        push,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0] idx;

  assign word_done = push && (idx == 2'd3);

  // Shifting in from the top leaves byte 0 at [7:0] after four pushes, so
  // the word is complete (and stable) on the edge that accepts byte 3.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx  <= '0;
      word <= '0;
    end else if (clr) begin
      idx  <= '0;
    end else if (push) begin
      idx  <= idx + 2'd1;
      word <= {byte_in, word[31:8]};
    end
  end

endmodule

// File: rtl/inst_rom_loader.sv
// Streams bytes into instruction memory: four bytes per word, one write
// strobe per word, then a trailing XOR checksum byte validates the load.
//   clk, rst          : clock, async active-low reset
//   start, len        : load request (IDLE only) and word count 0..2^ADDR_W
//   byte_in/valid     : incoming byte stream
//   byte_ready        : loader accepts a byte this cycle
//   we, waddr, wdata  : instruction-memory write port
//   busy              : load in progress (also holds CPU fetch)
//   done, err         : sticky outcome flags, cleared by the next start
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_t            state, state_n;
  logic [ADDR_W:0]   len_q, cnt, cnt_inc;
  logic [CSUM_W-1:0] csum, csum_rx;
  logic              csum_phase;   // all words written; next byte is the checksum
  logic              accept, push, word_done, start_ok;

  assign byte_ready = (state == S_RECV);
  assign accept     = byte_valid && byte_ready;
  assign push       = accept && !csum_phase;
  assign we         = (state == S_WRITE);
  assign busy       = (state == S_RECV) || (state == S_WRITE) || (state == S_CHECK);
  assign cnt_inc    = cnt + 1'b1;
  assign start_ok   = (state == S_IDLE) && start;

  inst_rom_loader_byte_packer u_byte_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (start_ok),
    .push      (push),
    .byte_in   (byte_in),
    .word      (wdata),
    .word_done (word_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (len == '0)          state_n = S_DONE;
          else if (len > MAX_LEN) state_n = S_ERROR;
          else                    state_n = S_RECV;
        end
      end
      S_RECV: begin
        if (accept) begin
          if (csum_phase)     state_n = S_CHECK;
          else if (word_done) state_n = S_WRITE;
        end
      end
      S_WRITE: state_n = S_RECV;
      S_CHECK: state_n = (csum_rx == csum) ? S_DONE : S_ERROR;
      S_DONE:  state_n = S_IDLE;
      S_ERROR: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      waddr      <= '0;
      cnt        <= '0;
      len_q      <= '0;
      csum       <= '0;
      csum_rx    <= '0;
      csum_phase <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            waddr      <= '0;
            cnt        <= '0;
            len_q      <= len;
            csum       <= '0;
            csum_phase <= 1'b0;
            // Zero-length and oversize loads resolve immediately.
            done       <= (len == '0);
            err        <= (len > MAX_LEN);
          end
        end
        S_RECV: begin
          if (accept) begin
            if (csum_phase) csum_rx <= byte_in;
            else            csum    <= csum ^ byte_in;
          end
        end
        S_WRITE: begin
          cnt <= cnt_inc;
          // Hold the address on the final word so a full-size load never
          // wraps back to word 0.
          if (cnt_inc < len_q) waddr      <= waddr + 1'b1;
          else                 csum_phase <= 1'b1;
        end
        S_CHECK: begin
          if (csum_rx == csum) done <= 1'b1;
          else                 err  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_rom_loader.sv
module tb_inst_rom_loader;

  localparam int AW = 6;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   len;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic          busy;
  logic          done;
  logic          err;

  int   errors = 0;
  int   checks = 0;
  wr_t  sb[$];
  logic [7:0] bq[$];

  inst_rom_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .we(we), .waddr(waddr), .wdata(wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: every write strobe is matched against the scoreboard.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (we === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_we: got addr %h data %h want no write", waddr, wdata);
        end else begin
          e = sb.pop_front();
          if (waddr !== e.a || wdata !== e.d) begin
            errors++;
            $display("FAIL write: got addr %h data %h want addr %h data %h",
                     waddr, wdata, e.a, e.d);
          end
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (byte_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got byte_ready %b want 1", byte_ready);
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic do_start(input logic [AW:0] n);
    start = 1'b1;
    len   = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Streams bq as data bytes, then the checksum byte, then checks the outcome.
  task automatic run_load(input string tag, input logic [AW:0] n, input logic [7:0] cs,
                          input bit send_cs, input bit gaps, input bit poke,
                          input bit exp_done, input bit exp_err);
    int t = 0;
    do_start(n);
    for (int i = 0; i < bq.size(); i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        byte_valid = 1'b0;
        byte_in    = 8'($urandom_range(0, 255));
        @(negedge clk);
      end
      if (poke && i == 101) begin
        chk({tag, "_busy_before_poke"}, 32'(busy), 32'd1);
        do_start('0);
      end
      send_byte(bq[i]);
      if (i % 4 == 3) chk({tag, "_we_latency"}, 32'(we), 32'd1);
    end
    if (send_cs) send_byte(cs);
    while (busy === 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_done"},     32'(done), 32'(exp_done));
    chk({tag, "_err"},      32'(err),  32'(exp_err));
    chk({tag, "_writes_left"}, 32'(sb.size()), 32'd0);
    @(negedge clk);
    chk({tag, "_done_sticky"}, 32'(done), 32'(exp_done));
    chk({tag, "_err_sticky"},  32'(err),  32'(exp_err));
    sb.delete();
    bq.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_we"},         32'(we),         32'd0);
    chk({tag, "_waddr"},      32'(waddr),      32'd0);
    chk({tag, "_wdata"},      wdata,           32'd0);
    chk({tag, "_busy"},       32'(busy),       32'd0);
    chk({tag, "_done"},       32'(done),       32'd0);
    chk({tag, "_err"},        32'(err),        32'd0);
  endtask

  initial begin
    logic [7:0] r[256];
    logic [7:0] x;
    rst = 1'b0; start = 1'b0; len = '0; byte_in = '0; byte_valid = 1'b0;
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // len=1: 13 00 00 20, checksum 0x33
    bq = '{8'h13, 8'h00, 8'h00, 8'h20};
    sb.push_back('{a: 6'd0, d: 32'h2000_0013});
    run_load("len1", 7'd1, 8'h33, 1, 0, 0, 1, 0);

    // len=2: 01..08, checksum 0x08
    bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    sb.push_back('{a: 6'd0, d: 32'h0403_0201});
    sb.push_back('{a: 6'd1, d: 32'h0807_0605});
    run_load("len2", 7'd2, 8'h08, 1, 1, 0, 1, 0);

    // len=1: AA BB CC DD XOR to 0x00; sending 0x44 must be rejected
    bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    sb.push_back('{a: 6'd0, d: 32'hDDCC_BBAA});
    run_load("badcs", 7'd1, 8'h44, 1, 0, 0, 0, 1);

    // len=0: straight to DONE, no writes, no checksum byte
    run_load("len0", 7'd0, 8'h00, 0, 0, 0, 1, 0);

    // len=65: illegal, straight to ERROR
    run_load("len65", 7'd65, 8'h00, 0, 0, 0, 0, 1);

    // len=64: random bytes, random valid gaps, start poked mid-load
    x = 8'h00;
    for (int i = 0; i < 256; i++) begin
      r[i] = 8'($urandom_range(0, 255));
      x    = x ^ r[i];
      bq.push_back(r[i]);
    end
    for (int w = 0; w < 64; w++)
      sb.push_back('{a: 6'(w), d: {r[4*w+3], r[4*w+2], r[4*w+1], r[4*w]}});
    run_load("len64", 7'd64, x, 1, 1, 1, 1, 0);

    // Async reset mid-RECV: outputs clear without a clock edge
    do_start(7'd2);
    sb.push_back('{a: 6'd0, d: 32'h4433_2211});
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    chk("rstmid_we_latency", 32'(we), 32'd1);
    send_byte(8'h55);
    chk("rstmid_in_recv", 32'(busy), 32'd1);
    #3;
    rst = 1'b0;
    #1;
    chk_reset_outputs("rstmid");
    chk("rstmid_writes_left", 32'(sb.size()), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_idle_busy", 32'(busy), 32'd0);

    // Loader is usable again after the aborted load
    bq = '{8'h13, 8'h00, 8'h00, 8'h20};
    sb.push_back('{a: 6'd0, d: 32'h2000_0013});
    run_load("again", 7'd1, 8'h33, 1, 1, 0, 1, 0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
